cond_flags_unit: RTL and testbench
==================================

// Module: cond_flags_unit
// PURPOSE
//  Status-register end of the ALU datapath: captures the ALU carry/zero/neg/over outputs into the CPU flags register,
//  returns the registered carry to the ALU carry_in, and evaluates 4-bit branch conditions against the held flags.
//  Holds a small LIFO of saved flag sets for interrupt entry/exit. Sits between the ALU and the control/branch logic.
// PARAMETERS
//  STACK_DEPTH  4  flag-save LIFO entries (power of two, 2..16)
// PORTS
//  clock            in   1  system clock; all state changes on rising edge
//  reset            in   1  synchronous, active-high
//  alu_carry        in   1  ALU carry_out
//  alu_zero         in   1  ALU zero_out
//  alu_neg          in   1  ALU neg_out
//  alu_over         in   1  ALU over_out
//  flags_write      in   1  capture ALU flags selected by flags_mask this cycle
//  flags_mask       in   4  per-flag write enable, t_flags bit order
//  flags_load       in   1  overwrite flags from flags_load_data (move-to-flags instruction)
//  flags_load_data  in   4  replacement flags, t_flags bit order
//  cond             in   4  t_cond branch condition to evaluate
//  push             in   1  save current flags to LIFO
//  pop              in   1  restore flags from LIFO
//  clear_error      in   1  clear sticky stack_error
//  flags            out  4  registered flags: [0]=C [1]=Z [2]=N [3]=V
//  carry            out  1  flags[0]; drives ALU carry_in
//  cond_true        out  1  combinational result of cond against registered flags
//  stack_full       out  1  LIFO holds STACK_DEPTH entries
//  stack_empty      out  1  LIFO holds 0 entries
//  stack_error      out  1  sticky: overflow, underflow or push+pop collision
// BEHAVIOUR
//  - Reset: flags=4'b0000, LIFO count=0, stack_error=0; thus stack_empty=1, stack_full=0, carry=0.
//    Reset mid-operation discards all LIFO contents and any same-cycle request.
//  - Flags-register update priority per cycle: pop (valid) > flags_load > flags_write > hold.
//    flags_write: flags[i] <= alu_flag[i] where flags_mask[i]=1, else unchanged. Mask 0 = no effect.
//  - Latency: new flags visible on flags/carry/cond_true the cycle after the write edge; no bypass.
//  - C is a borrow after subtract (ALU convention): unsigned a<b gives C=1.
//  - cond decode: 0 AL=1; 1 NV=0; 2 EQ=Z; 3 NE=!Z; 4 LO/CS=C; 5 HS/CC=!C; 6 MI=N; 7 PL=!N; 8 VS=V; 9 VC=!V;
//    A HI=!C&!Z; B LS=C|Z; C GE=N==V; D LT=N!=V; E GT=!Z&(N==V); F LE=Z|(N!=V).
//  - LIFO states by count: EMPTY(0), PARTIAL(1..DEPTH-1), FULL(DEPTH).
//    push, count<DEPTH: store pre-edge flags (value before any same-cycle write/load), count+1.
//    pop, count>0: flags <= top entry, count-1; same-cycle flags_write/flags_load dropped.
//    push when FULL or pop when EMPTY: no state change in LIFO or flags from that request, stack_error<=1;
//      a same-cycle write/load still applies in the push-full case and in the pop-empty case.
//    push & pop same cycle: LIFO and flags unchanged by both, stack_error<=1; write/load still apply.
//    stack_error set wins over clear_error in the same cycle.
// CONFIGURATION
//  FLAG_STACK_EN defined: LIFO and stack behaviour as above.
//  FLAG_STACK_EN undefined: no LIFO storage; push/pop ignored; stack_full=0, stack_empty=1, stack_error=0.
// STRUCTURE
//  cond_flags.vh: typedef t_flags (4 bits), FLAG_C/Z/N/V bit-index localparams, typedef enum t_cond (16 codes above).
//  Sub-module flag_stack (parameter DEPTH; push/pop/data/full/empty/error), instantiated only under FLAG_STACK_EN.
//  Condition decode stays inline as a combinational case in this module.
// TESTING
//  1 reset, then cond=AL/NV -> cond_true=1/0; flags=0, stack_empty=1, stack_error=0.
//  2 ALU C=1 Z=0 N=1 V=0, flags_write mask=4'b0101 -> next cycle flags=4'b0101, carry=1; mask=0 -> unchanged.
//  3 flags set from 5-7 (C=1,N=1,V=0): LO=1, HS=0, LT=1, GE=0, LS=1, HI=0; from 7-5 (flags 0): GT=1, HI=1.
//  4 push 4 distinct values (1,2,4,8) -> stack_full; 5th push -> stack_error=1, count stays 4; pops return 8,4,2,1.
//  5 pop on empty with flags_write mask=4'hF -> flags take ALU values, stack_error=1; clear_error -> 0.
//  6 push with flags_write same cycle -> LIFO holds old flags, register holds new; pop restores old. Build without FLAG_STACK_EN: push/pop no-op, stack_empty=1.

Source files
------------

// File: rtl/cond_flags_unit_pkg.sv
// Shared types for the condition/flags unit.
//   t_flags  : 4-bit flag vector, bit order [0]=C [1]=Z [2]=N [3]=V
//   FLAG_*   : bit indices into t_flags
//   t_cond   : 4-bit branch condition codes
//   flags_merge : masked per-bit update of a flag vector
package cond_flags_unit_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef logic [3:0] t_flags;

  typedef enum logic [3:0] {
    COND_AL = 4'h0,
    COND_NV = 4'h1,
    COND_EQ = 4'h2,
    COND_NE = 4'h3,
    COND_LO = 4'h4,
    COND_HS = 4'h5,
    COND_MI = 4'h6,
    COND_PL = 4'h7,
    COND_VS = 4'h8,
    COND_VC = 4'h9,
    COND_HI = 4'hA,
    COND_LS = 4'hB,
    COND_GE = 4'hC,
    COND_LT = 4'hD,
    COND_GT = 4'hE,
    COND_LE = 4'hF
  } t_cond;

  // Bits selected by mask take the new value, the rest keep the old one.
  function automatic t_flags flags_merge(input t_flags old_f, input t_flags new_f,
                                         input t_flags mask);
    return (old_f & ~mask) | (new_f & mask);
  endfunction

endpackage

// File: rtl/cond_flags_unit_flag_stack.sv
// flag_stack: LIFO of saved flag sets used around interrupt entry/exit.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   push, pop           : save data_in / discard top entry
//   clear_error         : clear the sticky error bit (a same-cycle error wins)
//   data_in             : flags to save (pre-edge register value)
//   data_out            : current top entry (meaningful only when not empty)
//   pop_ok              : a pop is accepted this cycle; the owner restores data_out
//   full, empty, error  : occupancy status and sticky misuse flag
module flag_stack
  import cond_flags_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   clear_error,
  input  t_flags data_in,
  output t_flags data_out,
  output logic   pop_ok,
  output logic   full,
  output logic   empty,
  output logic   error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  t_flags             mem_r [DEPTH];
  logic [CNT_W-1:0]   count_r;
  logic               error_r;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [IDX_W-1:0]   top_idx_s;
  logic               push_ok_s;
  logic               err_set_s;

  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});
  assign error = error_r;

  // Low index bits suffice: at count==DEPTH they wrap to 0 and top becomes DEPTH-1.
  assign wr_idx_s  = count_r[IDX_W-1:0];
  assign top_idx_s = count_r[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1};
  assign data_out  = mem_r[top_idx_s];

  // A simultaneous push and pop cancels both and counts as misuse.
  assign push_ok_s = push & ~pop & ~full;
  assign pop_ok    = pop & ~push & ~empty;
  assign err_set_s = (push & pop) | (push & full) | (pop & empty);

  // Entry storage; stale entries above count are never read.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_r[wr_idx_s] <= data_in;
    end
  end

  // Occupancy count and sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
      error_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (pop_ok) begin
        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
      if (err_set_s) begin
        error_r <= 1'b1;
      end else if (clear_error) begin
        error_r <= 1'b0;
      end else begin
        error_r <= error_r;
      end
    end
  end

endmodule

// File: rtl/cond_flags_unit.sv
// cond_flags_unit: CPU flags register at the end of the ALU datapath.
// Captures ALU C/Z/N/V under a per-bit mask, supports a direct flags load,
// feeds the registered carry back to the ALU, evaluates branch conditions
// against the held flags, and optionally saves/restores flags on a LIFO.
// Configuration macro FLAG_STACK_EN: when defined the flag_stack LIFO is
// built; when undefined push/pop are ignored, stack_full=0, stack_empty=1,
// stack_error=0.
// Ports:
//   clock, reset                  : rising-edge clock, synchronous active-high reset
//   alu_carry/zero/neg/over       : ALU flag outputs
//   flags_write, flags_mask       : masked capture of ALU flags
//   flags_load, flags_load_data   : overwrite of the whole flags register
//   cond                          : branch condition code to evaluate
//   push, pop, clear_error        : LIFO control
//   flags, carry                  : registered flags and C bit
//   cond_true                     : combinational condition result
//   stack_full/empty/error        : LIFO status
module cond_flags_unit
  import cond_flags_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       alu_over,
  input  logic       flags_write,
  input  logic [3:0] flags_mask,
  input  logic       flags_load,
  input  logic [3:0] flags_load_data,
  input  logic [3:0] cond,
  input  logic       push,
  input  logic       pop,
  input  logic       clear_error,
  output logic [3:0] flags,
  output logic       carry,
  output logic       cond_true,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_error
);

  t_flags flags_r;
  t_flags flags_nxt_s;
  t_flags alu_flags_s;
  t_flags stack_top_s;
  logic   pop_ok_s;
  logic   c_s, z_s, n_s, v_s;

  always_comb begin
    alu_flags_s         = 4'b0000;
    alu_flags_s[FLAG_C] = alu_carry;
    alu_flags_s[FLAG_Z] = alu_zero;
    alu_flags_s[FLAG_N] = alu_neg;
    alu_flags_s[FLAG_V] = alu_over;
  end

`ifdef FLAG_STACK_EN
  flag_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clock       (clock),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .clear_error (clear_error),
    .data_in     (flags_r),
    .data_out    (stack_top_s),
    .pop_ok      (pop_ok_s),
    .full        (stack_full),
    .empty       (stack_empty),
    .error       (stack_error)
  );
`else
  logic unused_s;
  assign unused_s    = push ^ pop ^ clear_error ^ (STACK_DEPTH == 0);
  assign stack_top_s = 4'b0000;
  assign pop_ok_s    = 1'b0;
  assign stack_full  = 1'b0;
  assign stack_empty = 1'b1;
  assign stack_error = 1'b0;
`endif

  // Next-flags priority: accepted pop, then load, then masked ALU capture.
  always_comb begin
    flags_nxt_s = flags_r;
    if (pop_ok_s) begin
      flags_nxt_s = stack_top_s;
    end else if (flags_load) begin
      flags_nxt_s = flags_load_data;
    end else if (flags_write) begin
      flags_nxt_s = flags_merge(flags_r, alu_flags_s, flags_mask);
    end else begin
      flags_nxt_s = flags_r;
    end
  end

  // Flags register.
  always_ff @(posedge clock) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

  assign flags = flags_r;
  assign carry = flags_r[FLAG_C];
  assign c_s   = flags_r[FLAG_C];
  assign z_s   = flags_r[FLAG_Z];
  assign n_s   = flags_r[FLAG_N];
  assign v_s   = flags_r[FLAG_V];

  // Branch condition decode; C is a borrow, so LO means C=1.
  always_comb begin
    cond_true = 1'b0;
    case (t_cond'(cond))
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      COND_EQ: cond_true = z_s;
      COND_NE: cond_true = ~z_s;
      COND_LO: cond_true = c_s;
      COND_HS: cond_true = ~c_s;
      COND_MI: cond_true = n_s;
      COND_PL: cond_true = ~n_s;
      COND_VS: cond_true = v_s;
      COND_VC: cond_true = ~v_s;
      COND_HI: cond_true = ~c_s & ~z_s;
      COND_LS: cond_true = c_s | z_s;
      COND_GE: cond_true = (n_s == v_s);
      COND_LT: cond_true = (n_s != v_s);
      COND_GT: cond_true = ~z_s & (n_s == v_s);
      COND_LE: cond_true = z_s | (n_s != v_s);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cond_flags_unit.sv
// Self-checking bench for cond_flags_unit. The driver sets inputs shortly
// after a rising edge and queues the values expected after the next edge;
// a monitor samples 1 ns after every rising edge and checks due entries.
module tb_cond_flags_unit;
  import cond_flags_unit_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       alu_carry, alu_zero, alu_neg, alu_over;
  logic       flags_write;
  logic [3:0] flags_mask;
  logic       flags_load;
  logic [3:0] flags_load_data;
  logic [3:0] cond;
  logic       push, pop, clear_error;
  logic [3:0] flags;
  logic       carry, cond_true, stack_full, stack_empty, stack_error;

  cond_flags_unit #(.STACK_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .alu_carry       (alu_carry),
    .alu_zero        (alu_zero),
    .alu_neg         (alu_neg),
    .alu_over        (alu_over),
    .flags_write     (flags_write),
    .flags_mask      (flags_mask),
    .flags_load      (flags_load),
    .flags_load_data (flags_load_data),
    .cond            (cond),
    .push            (push),
    .pop             (pop),
    .clear_error     (clear_error),
    .flags           (flags),
    .carry           (carry),
    .cond_true       (cond_true),
    .stack_full      (stack_full),
    .stack_empty     (stack_empty),
    .stack_error     (stack_error)
  );

  always #5 clock = ~clock;

  typedef enum int {SEL_FLAGS, SEL_CARRY, SEL_COND, SEL_FULL, SEL_EMPTY, SEL_ERROR} t_sel;
  typedef struct {
    string      name;
    t_sel       sel;
    logic [3:0] exp;
    int         due;
  } t_exp;

  t_exp exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  // Monitor: samples after each edge and checks every entry due this cycle.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        t_exp       e;
        logic [3:0] act;
        e = exp_q.pop_front();
        case (e.sel)
          SEL_FLAGS: act = flags;
          SEL_CARRY: act = {3'b000, carry};
          SEL_COND:  act = {3'b000, cond_true};
          SEL_FULL:  act = {3'b000, stack_full};
          SEL_EMPTY: act = {3'b000, stack_empty};
          default:   act = {3'b000, stack_error};
        endcase
        checks++;
        if (act !== e.exp || e.due != cyc) begin
          failures++;
          $display("FAIL %s: got %b expected %b (cycle %0d due %0d)", e.name, act, e.exp, cyc, e.due);
        end
      end
    end
  end

  // Queue a value expected after the coming edge.
  task automatic expect_v(input string name, input t_sel sel, input logic [3:0] v);
    t_exp e;
    e.name = name; e.sel = sel; e.exp = v; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #3;
  endtask

  task automatic idle();
    alu_carry = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; alu_over = 1'b0;
    flags_write = 1'b0; flags_mask = 4'b0000;
    flags_load = 1'b0; flags_load_data = 4'b0000;
    push = 1'b0; pop = 1'b0; clear_error = 1'b0;
  endtask

  // alu vector uses flag order {V,N,Z,C}
  task automatic set_alu(input logic [3:0] a);
    alu_carry = a[0]; alu_zero = a[1]; alu_neg = a[2]; alu_over = a[3];
  endtask

  task automatic load(input logic [3:0] d);
    idle(); flags_load = 1'b1; flags_load_data = d;
  endtask

  task automatic cond_chk(input string name, input logic [3:0] c, input logic v);
    idle(); cond = c;
    expect_v(name, SEL_COND, {3'b000, v});
    step();
  endtask

  initial begin
    idle();
    cond  = 4'h0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // 1: reset state
    cond = COND_AL;
    expect_v("rst_flags", SEL_FLAGS, 4'b0000);
    expect_v("rst_carry", SEL_CARRY, 4'b0000);
    expect_v("rst_empty", SEL_EMPTY, 4'b0001);
    expect_v("rst_full",  SEL_FULL,  4'b0000);
    expect_v("rst_error", SEL_ERROR, 4'b0000);
    expect_v("rst_al",    SEL_COND,  4'b0001);
    step();
    cond_chk("rst_nv", COND_NV, 1'b0);

    // 2: masked capture
    idle(); set_alu(4'b0101); flags_write = 1'b1; flags_mask = 4'b0101;
    expect_v("wr_mask5", SEL_FLAGS, 4'b0101);
    expect_v("wr_carry", SEL_CARRY, 4'b0001);
    step();
    idle(); set_alu(4'b1111); flags_write = 1'b1; flags_mask = 4'b0000;
    expect_v("wr_mask0", SEL_FLAGS, 4'b0101);
    step();
    idle(); set_alu(4'b0010); flags_write = 1'b1; flags_mask = 4'b1010;
    expect_v("wr_maskA", SEL_FLAGS, 4'b0111);
    step();
    idle(); set_alu(4'b0110); flags_write = 1'b1; flags_mask = 4'b1111;
    flags_load = 1'b1; flags_load_data = 4'b1000;
    expect_v("load_over_write", SEL_FLAGS, 4'b1000);
    expect_v("load_carry",      SEL_CARRY, 4'b0000);
    step();

    // 3: conditions, 5-7 -> C=1 N=1 V=0 Z=0
    load(4'b0101); step();
    cond_chk("lo", COND_LO, 1'b1);
    cond_chk("hs", COND_HS, 1'b0);
    cond_chk("lt", COND_LT, 1'b1);
    cond_chk("ge", COND_GE, 1'b0);
    cond_chk("ls", COND_LS, 1'b1);
    cond_chk("hi", COND_HI, 1'b0);
    cond_chk("mi", COND_MI, 1'b1);
    load(4'b0000); step();
    cond_chk("gt", COND_GT, 1'b1);
    cond_chk("hi0", COND_HI, 1'b1);
    cond_chk("le0", COND_LE, 1'b0);
    load(4'b0010); step();
    cond_chk("eq", COND_EQ, 1'b1);
    cond_chk("ne", COND_NE, 1'b0);
    cond_chk("le", COND_LE, 1'b1);
    load(4'b1000); step();
    cond_chk("vs", COND_VS, 1'b1);
    cond_chk("gt_v", COND_GT, 1'b0);

`ifdef FLAG_STACK_EN
    // 4: fill the LIFO; each push saves the pre-edge value while a load lands
    load(4'b0001); step();
    load(4'b0010); push = 1'b1; expect_v("push1_flags", SEL_FLAGS, 4'b0010); step();
    load(4'b0100); push = 1'b1; step();
    load(4'b1000); push = 1'b1; step();
    idle(); push = 1'b1;
    expect_v("full4", SEL_FULL, 4'b0001);
    expect_v("full4_empty", SEL_EMPTY, 4'b0000);
    step();
    load(4'b0011); push = 1'b1;
    expect_v("ovf_error", SEL_ERROR, 4'b0001);
    expect_v("ovf_load",  SEL_FLAGS, 4'b0011);
    expect_v("ovf_full",  SEL_FULL,  4'b0001);
    step();
    idle(); pop = 1'b1;
    expect_v("pop8", SEL_FLAGS, 4'b1000);
    expect_v("pop8_full", SEL_FULL, 4'b0000);
    step();
    load(4'b1111); pop = 1'b1; expect_v("pop4_dropload", SEL_FLAGS, 4'b0100); step();
    idle(); pop = 1'b1; expect_v("pop2", SEL_FLAGS, 4'b0010); step();
    idle(); pop = 1'b1;
    expect_v("pop1", SEL_FLAGS, 4'b0001);
    expect_v("pop1_empty", SEL_EMPTY, 4'b0001);
    step();
    idle(); clear_error = 1'b1; expect_v("clr_err", SEL_ERROR, 4'b0000); step();

    // 5: pop on empty, ALU capture still applies; error beats clear
    idle(); pop = 1'b1; clear_error = 1'b1; set_alu(4'b1010);
    flags_write = 1'b1; flags_mask = 4'b1111;
    expect_v("unf_flags", SEL_FLAGS, 4'b1010);
    expect_v("unf_error", SEL_ERROR, 4'b0001);
    step();
    idle(); clear_error = 1'b1; expect_v("clr_err2", SEL_ERROR, 4'b0000); step();

    // 6: push with write; pop restores the old flags
    idle(); push = 1'b1; set_alu(4'b0101); flags_write = 1'b1; flags_mask = 4'b1111;
    expect_v("pushwr_flags", SEL_FLAGS, 4'b0101);
    expect_v("pushwr_empty", SEL_EMPTY, 4'b0000);
    step();
    load(4'b1100); push = 1'b1; pop = 1'b1;
    expect_v("pp_flags", SEL_FLAGS, 4'b1100);
    expect_v("pp_error", SEL_ERROR, 4'b0001);
    expect_v("pp_empty", SEL_EMPTY, 4'b0000);
    step();
    idle(); pop = 1'b1;
    expect_v("restore", SEL_FLAGS, 4'b1010);
    expect_v("restore_empty", SEL_EMPTY, 4'b0001);
    step();
`else
    // 6 (no stack): push/pop are no-ops
    load(4'b0110); push = 1'b1;
    expect_v("ns_push_flags", SEL_FLAGS, 4'b0110);
    expect_v("ns_empty", SEL_EMPTY, 4'b0001);
    expect_v("ns_full",  SEL_FULL,  4'b0000);
    step();
    idle(); pop = 1'b1; set_alu(4'b1001); flags_write = 1'b1; flags_mask = 4'b1111;
    expect_v("ns_pop_flags", SEL_FLAGS, 4'b1001);
    expect_v("ns_pop_error", SEL_ERROR, 4'b0000);
    step();
    idle(); push = 1'b1; pop = 1'b1;
    expect_v("ns_pp_error", SEL_ERROR, 4'b0000);
    expect_v("ns_pp_flags", SEL_FLAGS, 4'b1001);
    step();
`endif

    // mid-operation reset clears flags even with a load pending
    load(4'b1111); reset = 1'b1;
    expect_v("rst2_flags", SEL_FLAGS, 4'b0000);
    expect_v("rst2_error", SEL_ERROR, 4'b0000);
    expect_v("rst2_empty", SEL_EMPTY, 4'b0001);
    step();
    reset = 1'b0; idle();

    // drain with a bound
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
